// File: rtl/rv_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit for the EX stage.
// Shift-add multiply and restoring divide run on operand magnitudes; signs are fixed up in a final cycle.
module rv_muldiv_unit #(
    parameter int XLEN          = 32,
    parameter int MUL_BPC       = 2,
    parameter int DIV_BPC       = 1,
    parameter int DIV_EARLY_OUT = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [2:0]      i_f3,
    input  logic            i_kill,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_res,
    output logic            o_busy
);

    localparam int MIN_BPC = (MUL_BPC < DIV_BPC) ? MUL_BPC : DIV_BPC;
    localparam int CNT_W   = $clog2(XLEN / MIN_BPC) + 1;
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(XLEN / MUL_BPC - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN / DIV_BPC - 1);
    localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]  ZERO_X   = {XLEN{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
        return ~v + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v);
        return ~v + {{(2*XLEN-1){1'b0}}, 1'b1};
    endfunction

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          f3_q, f3_d;
    logic                neg_res_q, neg_res_d;
    logic                neg_rem_q, neg_rem_d;
    logic                special_q, special_d;
    logic [XLEN-1:0]     special_res_q, special_res_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     res_q, res_d;
    logic                valid_q, valid_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;

    logic                rs1_neg_s, rs2_neg_s;
    logic                div_zero_s, div_ovf_s, special_in_s;
    logic [XLEN-1:0]     special_val_s;
    logic [XLEN-1:0]     rs1_abs_s, rs2_abs_s;
    logic [XLEN-1:0]     m_hi_s, m_lo_s;
    logic [XLEN:0]       m_sum_s;
    logic [XLEN-1:0]     d_rem_s, d_quo_s;
    logic [XLEN:0]       d_shift_s, d_diff_s;
    logic [2*XLEN-1:0]   prod_fix_s;
    logic [XLEN-1:0]     fix_res_s;

    // Request decode: operand signs, magnitudes and divide corner cases
    always_comb begin
        rs1_neg_s     = 1'b0;
        rs2_neg_s     = 1'b0;
        special_val_s = ZERO_X;
        case (i_f3)
            3'd1, 3'd4, 3'd6: begin
                rs1_neg_s = i_rs1[XLEN-1];
                rs2_neg_s = i_rs2[XLEN-1];
            end
            3'd2: begin
                rs1_neg_s = i_rs1[XLEN-1];
                rs2_neg_s = 1'b0;
            end
            default: begin
                rs1_neg_s = 1'b0;
                rs2_neg_s = 1'b0;
            end
        endcase
        rs1_abs_s    = rs1_neg_s ? neg_x(i_rs1) : i_rs1;
        rs2_abs_s    = rs2_neg_s ? neg_x(i_rs2) : i_rs2;
        div_zero_s   = (i_rs2 == ZERO_X);
        div_ovf_s    = ((i_f3 == 3'd4) || (i_f3 == 3'd6)) &&
                       (i_rs1 == MOST_NEG) && (i_rs2 == ALL_ONES);
        special_in_s = i_f3[2] && (div_zero_s || div_ovf_s);
        if (div_zero_s) begin
            special_val_s = i_f3[1] ? i_rs1 : ALL_ONES;
        end else begin
            special_val_s = i_f3[1] ? ZERO_X : i_rs1;
        end
    end

    // One CALC cycle of shift-add multiply and restoring divide
    always_comb begin
        m_hi_s    = acc_q[2*XLEN-1:XLEN];
        m_lo_s    = acc_q[XLEN-1:0];
        m_sum_s   = {(XLEN+1){1'b0}};
        for (int i = 0; i < MUL_BPC; i++) begin
            m_sum_s = {1'b0, m_hi_s} + (m_lo_s[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
            m_hi_s  = m_sum_s[XLEN:1];
            m_lo_s  = {m_sum_s[0], m_lo_s[XLEN-1:1]};
        end
        d_rem_s   = acc_q[2*XLEN-1:XLEN];
        d_quo_s   = acc_q[XLEN-1:0];
        d_shift_s = {(XLEN+1){1'b0}};
        d_diff_s  = {(XLEN+1){1'b0}};
        for (int i = 0; i < DIV_BPC; i++) begin
            d_shift_s = {d_rem_s, d_quo_s[XLEN-1]};
            d_diff_s  = d_shift_s - {1'b0, opnd_q};
            if (!d_diff_s[XLEN]) begin
                d_rem_s = d_diff_s[XLEN-1:0];
                d_quo_s = {d_quo_s[XLEN-2:0], 1'b1};
            end else begin
                d_rem_s = d_shift_s[XLEN-1:0];
                d_quo_s = {d_quo_s[XLEN-2:0], 1'b0};
            end
        end
    end

    // Sign correction and result selection for the FIX cycle
    always_comb begin
        prod_fix_s = neg_res_q ? neg_2x(acc_q) : acc_q;
        if (special_q) begin
            fix_res_s = special_res_q;
        end else if (!f3_q[2]) begin
            fix_res_s = (f3_q[1:0] == 2'b00) ? prod_fix_s[XLEN-1:0] : prod_fix_s[2*XLEN-1:XLEN];
        end else if (!f3_q[1]) begin
            fix_res_s = neg_res_q ? neg_x(acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
        end else begin
            fix_res_s = neg_rem_q ? neg_x(acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];
        end
    end

    // Next-state and registered-output logic; kill overrides every state
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        f3_d          = f3_q;
        neg_res_d     = neg_res_q;
        neg_rem_d     = neg_rem_q;
        special_d     = special_q;
        special_res_d = special_res_q;
        opnd_d        = opnd_q;
        acc_d         = acc_q;
        res_d         = res_q;
        if (i_kill) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_valid) begin
                        cnt_d         = {CNT_W{1'b0}};
                        f3_d          = i_f3;
                        neg_res_d     = rs1_neg_s ^ rs2_neg_s;
                        neg_rem_d     = rs1_neg_s;
                        special_d     = special_in_s;
                        special_res_d = special_val_s;
                        opnd_d        = rs2_abs_s;
                        acc_d         = {ZERO_X, rs1_abs_s};
                        state_d       = ((DIV_EARLY_OUT != 0) && special_in_s) ? S_FIX : S_CALC;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_CALC: begin
                    acc_d = f3_q[2] ? {d_rem_s, d_quo_s} : {m_hi_s, m_lo_s};
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_q == (f3_q[2] ? DIV_LAST : MUL_LAST)) begin
                        state_d = S_FIX;
                    end else begin
                        state_d = S_CALC;
                    end
                end
                S_FIX: begin
                    res_d   = fix_res_s;
                    state_d = S_DONE;
                end
                S_DONE: begin
                    if (i_ready) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
        valid_d = (state_d == S_DONE);
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= {CNT_W{1'b0}};
            f3_q          <= 3'd0;
            neg_res_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            special_q     <= 1'b0;
            special_res_q <= ZERO_X;
            opnd_q        <= ZERO_X;
            acc_q         <= {(2*XLEN){1'b0}};
            res_q         <= ZERO_X;
            valid_q       <= 1'b0;
            ready_q       <= 1'b1;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            f3_q          <= f3_d;
            neg_res_q     <= neg_res_d;
            neg_rem_q     <= neg_rem_d;
            special_q     <= special_d;
            special_res_q <= special_res_d;
            opnd_q        <= opnd_d;
            acc_q         <= acc_d;
            res_q         <= res_d;
            valid_q       <= valid_d;
            ready_q       <= ready_d;
            busy_q        <= busy_d;
        end
    end

    assign o_valid = valid_q;
    assign o_ready = ready_q;
    assign o_busy  = busy_q;
    assign o_res   = res_q;

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Directed bench for rv_muldiv_unit (XLEN=32, MUL_BPC=2, DIV_BPC=1, early-out on).
module tb_rv_muldiv_unit;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_rs1;
    logic [31:0] i_rs2;
    logic [2:0]  i_f3;
    logic        i_kill;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_res;
    logic        o_busy;

    int n_cmp = 0;
    int n_err = 0;

    rv_muldiv_unit #(
        .XLEN(32), .MUL_BPC(2), .DIV_BPC(1), .DIV_EARLY_OUT(1)
    ) dut (
        .i_clk  (clk),
        .i_rst  (i_rst),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_rs1  (i_rs1),
        .i_rs2  (i_rs2),
        .i_f3   (i_f3),
        .i_kill (i_kill),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_res  (o_res),
        .o_busy (o_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one op, scramble inputs after accept, measure latency, check result, then take it.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int lat;
        i_valid = 1'b1;
        i_f3    = f3;
        i_rs1   = a;
        i_rs2   = b;
        i_ready = 1'b0;
        tick();
        i_valid = 1'b0;
        i_rs1   = ~a;
        i_rs2   = a ^ b;
        i_f3    = ~f3;
        chk({tag, " busy"}, 64'(o_busy), 64'd1);
        chk({tag, " ready"}, 64'(o_ready), 64'd0);
        lat = 1;
        while (!o_valid && lat < 100) begin
            tick();
            lat++;
        end
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " res"}, 64'(o_res), 64'(exp_res));
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        chk({tag, " valid drop"}, 64'(o_valid), 64'd0);
        chk({tag, " idle"}, 64'(o_ready), 64'd1);
    endtask

    initial begin
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_rs1   = 32'd0;
        i_rs2   = 32'd0;
        i_f3    = 3'd0;
        i_kill  = 1'b0;
        i_ready = 1'b0;
        tick();
        tick();
        i_rst = 1'b0;
        chk("reset ready", 64'(o_ready), 64'd1);
        chk("reset valid", 64'(o_valid), 64'd0);
        chk("reset busy", 64'(o_busy), 64'd0);
        chk("reset res", 64'(o_res), 64'd0);

        // Multiply
        run_op("MUL 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 18);
        run_op("MULH min*min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 18);
        run_op("MULHSU -1*max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 18);
        run_op("MULHU max*max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 18);
        run_op("MULH -2*3", 3'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 18);
        run_op("MULHU 2^16*2^16", 3'd3, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 18);

        // Divide
        run_op("DIV -20/6", 3'd4, 32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFD, 34);
        run_op("REM -20/6", 3'd6, 32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFE, 34);
        run_op("DIVU 20/6", 3'd5, 32'd20, 32'd6, 32'd3, 34);
        run_op("REMU 20/6", 3'd7, 32'd20, 32'd6, 32'd2, 34);
        run_op("DIV 7/-2", 3'd4, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
        run_op("REM 7/-2", 3'd6, 32'd7, 32'hFFFF_FFFE, 32'd1, 34);

        // Early-out corner cases
        run_op("DIV x/0", 3'd4, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 2);
        run_op("DIVU 7/0", 3'd5, 32'd7, 32'd0, 32'hFFFF_FFFF, 2);
        run_op("REMU 5/0", 3'd7, 32'd5, 32'd0, 32'd5, 2);
        run_op("REM -7/0", 3'd6, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 2);
        run_op("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
        run_op("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2);

        // Kill in CALC cycle 5
        i_valid = 1'b1;
        i_f3    = 3'd0;
        i_rs1   = 32'd9;
        i_rs2   = 32'd9;
        tick();
        i_valid = 1'b0;
        for (int c = 1; c < 5; c++) begin
            chk("kill pre valid", 64'(o_valid), 64'd0);
            tick();
        end
        chk("kill cycle5 busy", 64'(o_busy), 64'd1);
        i_kill = 1'b1;
        tick();
        i_kill = 1'b0;
        chk("kill valid", 64'(o_valid), 64'd0);
        chk("kill ready", 64'(o_ready), 64'd1);
        chk("kill busy", 64'(o_busy), 64'd0);
        run_op("MUL 3*4 after kill", 3'd0, 32'd3, 32'd4, 32'd12, 18);

        // Kill together with valid in IDLE is not accepted
        i_valid = 1'b1;
        i_kill  = 1'b1;
        tick();
        i_valid = 1'b0;
        i_kill  = 1'b0;
        chk("kill+valid ready", 64'(o_ready), 64'd1);
        chk("kill+valid busy", 64'(o_busy), 64'd0);

        // Backpressure in DONE
        i_valid = 1'b1;
        i_f3    = 3'd5;
        i_rs1   = 32'd100;
        i_rs2   = 32'd7;
        tick();
        i_valid = 1'b0;
        for (int c = 1; c < 34; c++) begin
            tick();
        end
        chk("bp valid rise", 64'(o_valid), 64'd1);
        chk("bp res", 64'(o_res), 64'd14);
        i_valid = 1'b1;
        i_f3    = 3'd0;
        i_rs1   = 32'd1;
        i_rs2   = 32'd1;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("bp hold valid", 64'(o_valid), 64'd1);
            chk("bp hold res", 64'(o_res), 64'd14);
            chk("bp hold ready", 64'(o_ready), 64'd0);
        end
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        chk("bp release valid", 64'(o_valid), 64'd0);
        chk("bp no accept in DONE", 64'(o_busy), 64'd0);
        chk("bp release ready", 64'(o_ready), 64'd1);
        run_op("MUL 5*6 back-to-back", 3'd0, 32'd5, 32'd6, 32'd30, 18);

        // Reset in the middle of CALC
        i_valid = 1'b1;
        i_f3    = 3'd4;
        i_rs1   = 32'd50;
        i_rs2   = 32'd3;
        tick();
        i_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
        end
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk("midrst valid", 64'(o_valid), 64'd0);
        chk("midrst busy", 64'(o_busy), 64'd0);
        chk("midrst ready", 64'(o_ready), 64'd1);
        chk("midrst res", 64'(o_res), 64'd0);
        run_op("DIV 50/3 after reset", 3'd4, 32'd50, 32'd3, 32'd16, 34);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
